// File: rtl/div_reservation_station.sv
// -----------------------------------------------------------------------------
// div_reservation_station
//   Reservation station for the divide unit. Dispatched divide ops wait here
//   until both operands are valid. Pending operands are captured from the CDB.
//   The oldest ready entry goes to the divider stage under a ready/stall
//   handshake.
//
//   Storage is an age-ordered collapsing queue. Entry 0 is the oldest entry,
//   and valid entries always occupy slots 0..count-1.
//
// Ports
//   clk_i, reset_n_i              clock; asynchronous active-low reset
//   flush_i                       synchronous squash of every entry
//   dispatch*_i                   dispatch request, operands, tags, commands
//   full_o, count_o               occupancy
//   cdbValid_i/cdbTag_i/cdbVal_i  common data bus broadcast
//   reservationStation*_o         selected entry payload (0 when not ready)
//   readyRS_o, stallRS_i          issue handshake toward the divider
// -----------------------------------------------------------------------------
module div_reservation_station #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSdepth    = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic                         dispatchValid_i,
  input  logic [63:0]                  dispatchVal1_i,
  input  logic [63:0]                  dispatchVal2_i,
  input  logic                         dispatchRdy1_i,
  input  logic                         dispatchRdy2_i,
  input  logic [ROBsizeLog-1:0]        dispatchSrc1Tag_i,
  input  logic [ROBsizeLog-1:0]        dispatchSrc2Tag_i,
  input  logic [9:0]                   dispatchCommands_i,
  input  logic [ROBsizeLog-1:0]        dispatchTag_i,
  output logic                         full_o,
  output logic [$clog2(RSdepth+1)-1:0] count_o,
  input  logic                         cdbValid_i,
  input  logic [ROBsizeLog-1:0]        cdbTag_i,
  input  logic [63:0]                  cdbVal_i,
  output logic [63:0]                  reservationStationVal1_o,
  output logic [63:0]                  reservationStationVal2_o,
  output logic [9:0]                   reservationStationCommands_o,
  output logic [ROBsizeLog-1:0]        reservationStationTag_o,
  output logic                         readyRS_o,
  input  logic                         stallRS_i
);

  localparam int CW = $clog2(RSdepth + 1);
  localparam int IW = $clog2(RSdepth);

  typedef struct packed {
    logic                  rdy1;
    logic                  rdy2;
    logic [63:0]           val1;
    logic [63:0]           val2;
    logic [ROBsizeLog-1:0] src1_tag;
    logic [ROBsizeLog-1:0] src2_tag;
    logic [9:0]            commands;
    logic [ROBsizeLog-1:0] tag;
  } entry_t;

  logic [RSdepth-1:0] r_valid;
  entry_t             r_entry [RSdepth];
  logic [CW-1:0]      r_count;

  logic               w_sel_found;
  logic [IW-1:0]      w_sel_idx;
  logic               w_issue;
  logic               w_accept;
  logic [CW-1:0]      w_free_idx;
  entry_t             w_disp_entry;
  logic [RSdepth-1:0] w_nxt_valid;
  entry_t             w_nxt_entry [RSdepth];
  logic [CW-1:0]      w_nxt_count;

  // The selected entry is the oldest ready entry. The loop scans from the
  // youngest slot down to slot 0, so the last match it records is the oldest.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = RSdepth - 1; i >= 0; i--) begin
      if (r_valid[i] && r_entry[i].rdy1 && r_entry[i].rdy2) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IW'(i);
      end
    end
  end

  assign readyRS_o                    = w_sel_found;
  assign reservationStationVal1_o     = w_sel_found ? r_entry[w_sel_idx].val1     : '0;
  assign reservationStationVal2_o     = w_sel_found ? r_entry[w_sel_idx].val2     : '0;
  assign reservationStationCommands_o = w_sel_found ? r_entry[w_sel_idx].commands : '0;
  assign reservationStationTag_o      = w_sel_found ? r_entry[w_sel_idx].tag      : '0;

  assign full_o  = (r_count == CW'(RSdepth));
  assign count_o = r_count;

  assign w_issue    = w_sel_found & ~stallRS_i;
  // A dispatch is judged against this cycle's full_o, so a same-cycle issue
  // does not make room for it.
  assign w_accept   = dispatchValid_i & ~full_o & ~flush_i;
  assign w_free_idx = r_count - CW'(w_issue);

  // A new entry can catch a broadcast in the same cycle it is written, so
  // that wakeup is not lost.
  always_comb begin
    w_disp_entry          = '0;
    w_disp_entry.src1_tag = dispatchSrc1Tag_i;
    w_disp_entry.src2_tag = dispatchSrc2Tag_i;
    w_disp_entry.commands = dispatchCommands_i;
    w_disp_entry.tag      = dispatchTag_i;
    w_disp_entry.rdy1     = dispatchRdy1_i;
    w_disp_entry.val1     = dispatchVal1_i;
    w_disp_entry.rdy2     = dispatchRdy2_i;
    w_disp_entry.val2     = dispatchVal2_i;
    if (!dispatchRdy1_i && cdbValid_i && dispatchSrc1Tag_i == cdbTag_i) begin
      w_disp_entry.rdy1 = 1'b1;
      w_disp_entry.val1 = cdbVal_i;
    end
    if (!dispatchRdy2_i && cdbValid_i && dispatchSrc2Tag_i == cdbTag_i) begin
      w_disp_entry.rdy2 = 1'b1;
      w_disp_entry.val2 = cdbVal_i;
    end
  end

  // The next state is built in three steps: collapse, then wakeup, then
  // dispatch. Wakeup runs after the collapse, so a shifted entry is woken in
  // its new slot.
  always_comb begin
    w_nxt_valid = r_valid;
    w_nxt_entry = r_entry;

    if (w_issue) begin
      for (int i = 0; i < RSdepth - 1; i++) begin
        if (w_sel_idx <= IW'(i)) begin
          w_nxt_valid[i] = r_valid[i+1];
          w_nxt_entry[i] = r_entry[i+1];
        end
      end
      w_nxt_valid[RSdepth-1] = 1'b0;
    end

    if (cdbValid_i) begin
      for (int i = 0; i < RSdepth; i++) begin
        if (w_nxt_valid[i] && !w_nxt_entry[i].rdy1 && w_nxt_entry[i].src1_tag == cdbTag_i) begin
          w_nxt_entry[i].rdy1 = 1'b1;
          w_nxt_entry[i].val1 = cdbVal_i;
        end
        if (w_nxt_valid[i] && !w_nxt_entry[i].rdy2 && w_nxt_entry[i].src2_tag == cdbTag_i) begin
          w_nxt_entry[i].rdy2 = 1'b1;
          w_nxt_entry[i].val2 = cdbVal_i;
        end
      end
    end

    if (w_accept) begin
      for (int i = 0; i < RSdepth; i++) begin
        if (w_free_idx == CW'(i)) begin
          w_nxt_valid[i] = 1'b1;
          w_nxt_entry[i] = w_disp_entry;
        end
      end
    end

    if (flush_i) begin
      w_nxt_valid = '0;
    end

    if (flush_i) begin
      w_nxt_count = '0;
    end else begin
      w_nxt_count = r_count + CW'(w_accept) - CW'(w_issue);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop in
      // this block samples the pre-edge values.
      r_valid <= w_nxt_valid;
      r_count <= w_nxt_count;
    end
  end

  // NOTE: the payload array has no reset. The valid bits gate every use of
  // the payload, and resetting this wide array would only add reset routing.
  always_ff @(posedge clk_i) begin
    r_entry <= w_nxt_entry;
  end

endmodule
